// File: rtl/tb_ctrl_mmio_if.sv
// Core data-port request/response bundle for the testbench control region.
interface tb_ctrl_mmio_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output req, addr, we, be, wdata, input gnt, rdata, rvalid);
    modport slave  (input req, addr, we, be, wdata, output gnt, rdata, rvalid);
endinterface

// File: rtl/tb_ctrl_mmio.sv
// Testbench control peripheral: status/EOC capture, putchar FIFO, cycle timer.
// Optional feature macro: TB_CTRL_MMIO_TIMER_EN enables TSTART/TSTOP cycle counting.
module tb_ctrl_mmio #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    tb_ctrl_mmio_if.slave        bus,
    output logic                 eoc_o,
    output logic [31:0]          errors_o,
    output logic                 char_valid_o,
    output logic [7:0]           char_o,
    input  logic                 char_ready_i,
    output logic [CNT_W-1:0]     cycles_o
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        REG_STATUS  = 2'd0,
        REG_PUTCHAR = 2'd1,
        REG_TSTART  = 2'd2,
        REG_TSTOP   = 2'd3
    } reg_sel_e;

    reg_sel_e         sel;
    logic             full;
    logic             push;
    logic             pop;
    logic             wr_acc;
    logic [31:0]      rd_val;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [OCC_W-1:0] count;
    logic [7:0]       mem [FIFO_DEPTH];
    logic             unused_bits;

    always_comb sel = reg_sel_e'(bus.addr[3:2]);

    // Full comes from the registered count so a same-cycle pop never unblocks a push.
    assign full      = (count == OCC_W'(FIFO_DEPTH));
    assign bus.gnt   = bus.req & ~(bus.we & (sel == REG_PUTCHAR) & full);
    assign wr_acc    = bus.gnt & bus.we;
    assign push      = wr_acc & (sel == REG_PUTCHAR) & bus.be[0];
    assign pop       = char_valid_o & char_ready_i;

    assign char_valid_o = (count != '0);
    assign char_o       = char_valid_o ? mem[rptr] : '0;

    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.be[3:1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= bus.wdata[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            eoc_o    <= 1'b0;
            errors_o <= '1;
        end else if (wr_acc && sel == REG_STATUS) begin
            eoc_o    <= 1'b1;
            errors_o <= bus.wdata;
        end
    end

`ifdef TB_CTRL_MMIO_TIMER_EN
    logic             running;
    logic [CNT_W-1:0] cnt;
    logic             tstart;
    logic             tstop;

    assign tstart = wr_acc & (sel == REG_TSTART);
    assign tstop  = wr_acc & (sel == REG_TSTOP);

    // The TSTOP edge still counts; only a TSTART on the same edge suppresses the increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (tstart) begin
            running <= 1'b1;
            cnt     <= '0;
        end else begin
            if (running && cnt != '1) cnt <= cnt + 1'b1;
            if (tstop) running <= 1'b0;
        end
    end

    assign cycles_o = cnt;
`else
    assign cycles_o = '0;
`endif

    always_comb begin
        rd_val = '0;
        case (sel)
            REG_STATUS:  rd_val = errors_o;
            REG_PUTCHAR: rd_val = {{(32-OCC_W){1'b0}}, count};
            REG_TSTART,
            REG_TSTOP:   rd_val = 32'(cycles_o);
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            bus.rvalid <= bus.gnt;
            bus.rdata  <= (bus.gnt && !bus.we) ? rd_val : '0;
        end
    end
endmodule
